mips_multicycle_control: RTL

- Multicycle control FSM for the no-pipeline MIPS core.
- Decodes the opcode/funct encodings the bench driver emits: R-type add/sub/and/or/slt, j, beq, addiu, lw, sw, and check (6'b111111).
- Sequences the datapath through fetch/decode/execute/memory/writeback steps with a variable-latency memory handshake.
- On `check`, raises a valid/ready report toward the bench output monitor so the scoreboard can sample architectural state.

---
 rtl/mips_pkg.sv | 72 +++++++
 rtl/mips_alu_decoder.sv | 24 ++
 rtl/mips_multicycle_control.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM states, ALU/mux select codes and the packed control word.
package mips_pkg;

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_J     = 6'b000010,
        OP_BEQ   = 6'b000100,
        OP_ADDIU = 6'b001001,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_CHECK = 6'b111111
    } opcode_t;

    typedef enum logic [5:0] {
        FN_ADD = 6'b100000,
        FN_SUB = 6'b100010,
        FN_AND = 6'b100100,
        FN_OR  = 6'b100101,
        FN_SLT = 6'b101010
    } funct_t;

    typedef enum logic [3:0] {
        S_FETCH      = 4'd0,
        S_DECODE     = 4'd1,
        S_MEM_ADDR   = 4'd2,
        S_MEM_READ   = 4'd3,
        S_MEM_WB     = 4'd4,
        S_MEM_WRITE  = 4'd5,
        S_R_EXEC     = 4'd6,
        S_R_WB       = 4'd7,
        S_BRANCH     = 4'd8,
        S_JUMP       = 4'd9,
        S_ADDIU_EXEC = 4'd10,
        S_ADDIU_WB   = 4'd11,
        S_CHECK      = 4'd12
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT    = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Full set of datapath controls produced each cycle.
    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_ctrl;
        logic [1:0] pc_source;
        logic       check_valid;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mips_alu_decoder.sv
// R-type funct to ALU control; valid_o low flags an unsupported funct.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       valid_o
);

    // Unknown functs yield ALU_AND with valid_o low; the FSM never writes back then.
    always_comb begin
        alu_ctrl_o = ALU_AND;
        valid_o    = 1'b1;
        case (funct_t'(funct_i))
            FN_ADD:  alu_ctrl_o = ALU_ADD;
            FN_SUB:  alu_ctrl_o = ALU_SUB;
            FN_AND:  alu_ctrl_o = ALU_AND;
            FN_OR:   alu_ctrl_o = ALU_OR;
            FN_SLT:  alu_ctrl_o = ALU_SLT;
            default: valid_o    = 1'b0;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle control FSM: fetch/decode/execute/memory/writeback sequencing
// with a held memory request and a valid/ready check report. Only the state
// is registered; every control is decoded from state plus the gating inputs.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [5:0]         opcode_i,
    input  logic [5:0]         funct_i,
    input  logic               zero_i,
    input  logic               mem_ready_i,
    input  logic               check_ready_i,
    output logic               pc_write_o,
    output logic               i_or_d_o,
    output logic               mem_read_o,
    output logic               mem_write_o,
    output logic               ir_write_o,
    output logic               reg_dst_o,
    output logic               mem_to_reg_o,
    output logic               reg_write_o,
    output logic               alu_src_a_o,
    output logic [1:0]         alu_src_b_o,
    output logic [2:0]         alu_ctrl_o,
    output logic [1:0]         pc_source_o,
    output logic               check_valid_o,
    output logic               illegal_o,
    output logic [STATE_W-1:0] state_o
);

    // The FETCH step adds the constant 4, i.e. one WIDTH-bit word in bytes.
    if (WIDTH != 32) begin : g_width_chk
        $error("mips_multicycle_control: PC step of 4 assumes WIDTH == 32");
    end

    state_t     state;
    state_t     state_nxt;
    ctrl_t      ctrl;
    ctrl_t      ctrl_out;
    logic [2:0] r_alu_ctrl;
    logic       r_funct_ok;

    mips_alu_decoder u_alu_dec (
        .funct_i    (funct_i),
        .alu_ctrl_o (r_alu_ctrl),
        .valid_o    (r_funct_ok)
    );

    // State register; reset returns to FETCH and abandons the instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next-state and control decode.
    always_comb begin
        ctrl      = '0;
        state_nxt = state;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.alu_ctrl  = ALU_ADD;
                ctrl.pc_source = PCS_ALU;
                if (mem_ready_i) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed into ALUOut here.
                ctrl.alu_src_b = SRCB_IMMSH;
                ctrl.alu_ctrl  = ALU_ADD;
                case (opcode_t'(opcode_i))
                    OP_LW, OP_SW: state_nxt = S_MEM_ADDR;
                    OP_RTYPE:     state_nxt = S_R_EXEC;
                    OP_BEQ:       state_nxt = S_BRANCH;
                    OP_J:         state_nxt = S_JUMP;
                    OP_ADDIU:     state_nxt = S_ADDIU_EXEC;
                    OP_CHECK:     state_nxt = S_CHECK;
                    default: begin
                        ctrl.illegal = 1'b1;
                        state_nxt    = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
                state_nxt      = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
                if (mem_ready_i) state_nxt = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctrl.mem_to_reg = 1'b1;
                ctrl.reg_write  = 1'b1;
                state_nxt       = S_FETCH;
            end
            S_MEM_WRITE: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
                if (mem_ready_i) state_nxt = S_FETCH;
            end
            S_R_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_ctrl  = r_alu_ctrl;
                ctrl.illegal   = ~r_funct_ok;
                state_nxt      = r_funct_ok ? S_R_WB : S_FETCH;
            end
            S_R_WB: begin
                ctrl.reg_dst   = 1'b1;
                ctrl.reg_write = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_ctrl  = ALU_SUB;
                ctrl.pc_source = PCS_ALUOUT;
                ctrl.pc_write  = zero_i;
                state_nxt      = S_FETCH;
            end
            S_JUMP: begin
                ctrl.pc_source = PCS_JUMP;
                ctrl.pc_write  = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_ADDIU_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_ctrl  = ALU_ADD;
                state_nxt      = S_ADDIU_WB;
            end
            S_ADDIU_WB: begin
                ctrl.reg_write = 1'b1;
                state_nxt      = S_FETCH;
            end
            S_CHECK: begin
                // Valid stays up until the bench accepts it.
                ctrl.check_valid = 1'b1;
                if (check_ready_i) state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset gates every output combinationally so requests drop at once.
    assign ctrl_out = rst_n ? ctrl : ctrl_t'('0);

    assign pc_write_o    = ctrl_out.pc_write;
    assign i_or_d_o      = ctrl_out.i_or_d;
    assign mem_read_o    = ctrl_out.mem_read;
    assign mem_write_o   = ctrl_out.mem_write;
    assign ir_write_o    = ctrl_out.ir_write;
    assign reg_dst_o     = ctrl_out.reg_dst;
    assign mem_to_reg_o  = ctrl_out.mem_to_reg;
    assign reg_write_o   = ctrl_out.reg_write;
    assign alu_src_a_o   = ctrl_out.alu_src_a;
    assign alu_src_b_o   = ctrl_out.alu_src_b;
    assign alu_ctrl_o    = ctrl_out.alu_ctrl;
    assign pc_source_o   = ctrl_out.pc_source;
    assign check_valid_o = ctrl_out.check_valid;
    assign illegal_o     = ctrl_out.illegal;
    assign state_o       = rst_n ? STATE_W'(state) : '0;

endmodule
